// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
package sync_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_DATA_DEPTH = 16;

  localparam int ERR_W   = 2;
  localparam int ERR_OVF = 0;
  localparam int ERR_UDF = 1;

  function automatic int sync_fifo_aw(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// FIFO data/handshake bundle; master drives requests, slave is the FIFO.
interface sync_fifo_param_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DATA_DEPTH = DEF_DATA_DEPTH
) ();

  localparam int AW = sync_fifo_aw(DATA_DEPTH);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  full;
  logic                  almost_full;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  almost_empty;
  logic [AW:0]           count;
  logic                  overflow;
  logic                  underflow;
  logic                  clr_err;

  modport master (
    output wr_en, data_in, rd_en, clr_err,
    input  full, almost_full, data_out, empty, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en, clr_err,
    output full, almost_full, data_out, empty, almost_empty, count,
           overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// DATA_DEPTH x DATA_WIDTH storage, one write port and one asynchronous read
// address; no reset so it can be replaced by an SRAM macro.
module sync_fifo_mem #(
  parameter int DATA_WIDTH = 64,
  parameter int DATA_DEPTH = 16,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with count, thresholds and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read data.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DATA_DEPTH = DEF_DATA_DEPTH,
  parameter int AFULL_TH   = DATA_DEPTH - 4,
  parameter int AEMPTY_TH  = 4
) (
  input logic               clk,
  input logic               rst,
  sync_fifo_param_if.slave  bus
);

  localparam int AW = sync_fifo_aw(DATA_DEPTH);
  localparam logic [AW:0] CNT_MAX = (AW+1)'(DATA_DEPTH);
  localparam logic [AW:0] CNT_AF  = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] CNT_AE  = (AW+1)'(AEMPTY_TH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  if (DATA_WIDTH < 1)
    $fatal(1, "sync_fifo_param: DATA_WIDTH must be >= 1");
  if (DATA_DEPTH < 2 || (DATA_DEPTH & (DATA_DEPTH - 1)) != 0)
    $fatal(1, "sync_fifo_param: DATA_DEPTH must be a power of two >= 2");
  if (AFULL_TH < 1 || AFULL_TH > DATA_DEPTH)
    $fatal(1, "sync_fifo_param: AFULL_TH out of range");
  if (AEMPTY_TH < 0 || AEMPTY_TH > DATA_DEPTH - 1)
    $fatal(1, "sync_fifo_param: AEMPTY_TH out of range");

  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count_q, count_d;
  logic [ERR_W-1:0]      err_q, err_d;
  logic                  full, empty;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  assign full   = (count_q == CNT_MAX);
  assign empty  = (count_q == '0);
  assign wr_acc = bus.wr_en & ~full;
  assign rd_acc = bus.rd_en & ~empty;

  always_comb begin
    count_d = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Setting an error takes priority over clearing it in the same cycle.
  always_comb begin
    err_d          = err_q & {ERR_W{~bus.clr_err}};
    err_d[ERR_OVF] = err_d[ERR_OVF] | (bus.wr_en & full);
    err_d[ERR_UDF] = err_d[ERR_UDF] | (bus.rd_en & empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      err_q   <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DATA_DEPTH (DATA_DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (bus.data_in),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd_data)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.data_out = mem_rd_data;
`else
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         dout_q <= '0;
    else if (rd_acc) dout_q <= mem_rd_data;
  end

  assign bus.data_out = dout_q;
`endif

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CNT_AF);
  assign bus.almost_empty = (count_q <= CNT_AE);
  assign bus.count        = count_q;
  assign bus.overflow     = err_q[ERR_OVF];
  assign bus.underflow    = err_q[ERR_UDF];

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO with internally managed read/write pointers, an occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. Simultaneous read and write are handled exactly. It is the general-purpose on-chip buffer between SRAM-test datapath stages and replaces fixed 64x16 buffers that need externally supplied addresses. An optional first-word-fall-through (FWFT) read mode is selected at compile time.

## Interface
- DATA_WIDTH, 64, word width in bits (≥1)
- DATA_DEPTH, 16, number of entries; power of two, ≥2
- AFULL_TH, DATA_DEPTH-4, almost_full asserted when count ≥ AFULL_TH (1..DATA_DEPTH)
- AEMPTY_TH, 4, almost_empty asserted when count ≤ AEMPTY_TH (0..DATA_DEPTH-1)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write request
- data_in  in  DATA_WIDTH  write data
- full  out  1  count == DATA_DEPTH
- almost_full  out  1  count ≥ AFULL_TH
- rd_en  in  1  read request
- data_out  out  DATA_WIDTH  read data
- empty  out  1  count == 0
- almost_empty  out  1  count ≤ AEMPTY_TH
- count  out  AW+1  occupancy, AW = log2(DATA_DEPTH)
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty
- clr_err  in  1  synchronous clear of overflow/underflow

## Operation
- wr_acc = wr_en & ~full; rd_acc = rd_en & ~empty; both use pre-edge flags.
- wr_acc: mem[wr_ptr] <= data_in, wr_ptr += 1. rd_acc: rd_ptr += 1.
- Pointers are AW bits and wrap DATA_DEPTH-1 -> 0 naturally.
- count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither; never exceeds DATA_DEPTH nor drops below 0.
- Full + wr_en + rd_en: read accepted, write rejected, overflow set, count -> DATA_DEPTH-1.
- Empty + wr_en + rd_en: write accepted, read rejected, underflow set, count -> 1.
- Rejected accesses leave memory, pointers and data_out untouched.
- overflow/underflow: set on the offending cycle, held until clr_err; set wins over clr_err in the same cycle.
- Flags are pure decodes of registered count; no combinational path from wr_en/rd_en to any flag.

## Timing
- Reset (async assert, sync-safe deassert by system): pointers 0, count 0, empty 1, almost_empty 1, full 0, almost_full 0 (AFULL_TH ≥1), overflow 0, underflow 0, data_out 0. Memory contents not reset.
- Reset mid-operation discards all contents immediately; first write after deassert lands at entry 0.
- Standard mode: data_out registered; word available the cycle after rd_acc edge; held until next rd_acc.
- Write-to-empty-deassert latency: 1 cycle. Full deasserts 1 cycle after rd_acc.
- Throughput: one write and one read per cycle sustained.

## Configuration
- SYNC_FIFO_FWFT_EN defined: data_out = mem[rd_ptr] continuously (combinational from registered state); head word valid whenever empty = 0, i.e. 1 cycle after the first write; rd_en acknowledges/pops it; data_out undefined while empty.
- Undefined: standard registered read as above, data_out resets to 0.
- Pointer, count, flag and error behaviour identical in both modes.

## Structure
- Package sync_fifo_pkg: clog2-based AW helper function, default width/depth constants, error-flag bit indices.
- Sub-module sync_fifo_mem: DATA_DEPTH x DATA_WIDTH two-port array (1 write port, 1 read address port, no reset) so it can be swapped for an SRAM macro; control, count and flags stay in top.
- Parameter legality (power-of-two depth, threshold ranges) checked by elaboration-time assertions.

## Test plan
- Reset, write 16 words 0x1..0x10 (DEPTH 16) -> full=1, count=16, almost_full from count 12; 17th write -> overflow=1, count stays 16, mem unchanged.
- Read 16 words -> data_out 0x1..0x10 in order (standard: 1-cycle latency; FWFT: head visible before rd_en); extra read -> underflow=1, data_out holds 0x10.
- Simultaneous wr/rd at count 5 for 40 cycles -> count stays 5, pointers wrap, data order preserved.
- Full + wr_en + rd_en -> count 15, overflow=1; empty + both -> count 1, underflow=1.
- clr_err with new overflow same cycle -> overflow stays 1; clr_err alone -> 0.
- Assert rst at count 9 mid-burst -> all outputs to reset values same cycle; next write read back from entry 0.
